// File: rtl/bus_pkg.sv
// Shared types and constants for the serial system bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    CONNECTED = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  localparam int NUM_MASTERS   = 2;
  localparam int SLAVE_LEN_DEF = 2;

endpackage

// File: rtl/serial_sel_capture.sv
// MSB-first shift register for the bit-serial slave select, with a bit counter.
module serial_sel_capture
  import bus_pkg::*;
#(
  parameter int SLAVE_LEN = SLAVE_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bit_in,
  output logic                 done,
  output logic [SLAVE_LEN-1:0] index
);

  localparam int CW = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;

  logic [SLAVE_LEN-1:0] r_shift;
  logic [CW-1:0]        r_cnt;

  // index includes the bit being sampled this cycle so the decode lands on the last edge
  assign index = (r_shift << 1) | SLAVE_LEN'(bit_in);
  assign done  = start && (r_cnt == CW'(SLAVE_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_shift <= index;
      r_cnt   <= done ? '0 : r_cnt + CW'(1);
    end else begin
      r_cnt   <= '0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave select and watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int SLAVE_LEN  = SLAVE_LEN_DEF,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] approval_request,
  input  logic [NUM_MASTERS-1:0] tx_slave_select,
  input  logic [NUM_MASTERS-1:0] txn_done,
  output logic [NUM_MASTERS-1:0] approval_grant,
  output logic                   busy,
  output logic                   master_sel,
  output logic [NUM_SLAVES-1:0]  slave_en,
  output logic                   err
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t                 r_state, w_state_n;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_n;
  logic                   r_busy, w_busy_n;
  logic                   r_master_sel, w_master_sel_n;
  logic [NUM_SLAVES-1:0]  r_slave_en, w_slave_en_n;
  logic                   r_err, w_err_n;
  logic [TCW-1:0]         r_tcnt, w_tcnt_n;
  logic                   r_last, w_last_n;

  logic                   w_winner;
  logic                   w_req_own;
  logic                   w_done_own;
  logic                   w_bit;
  logic                   w_cap_start;
  logic                   w_cap_done;
  logic [SLAVE_LEN-1:0]   w_index;

  assign w_winner   = (approval_request == 2'b11) ? ~r_last : approval_request[1];
  assign w_req_own  = approval_request[r_master_sel];
  assign w_done_own = txn_done[r_master_sel];
  assign w_bit      = tx_slave_select[r_master_sel];

  serial_sel_capture #(
    .SLAVE_LEN(SLAVE_LEN)
  ) u_capture (
    .clk   (clk),
    .reset (reset),
    .start (w_cap_start),
    .bit_in(w_bit),
    .done  (w_cap_done),
    .index (w_index)
  );

  always_comb begin
    w_state_n      = r_state;
    w_grant_n      = r_grant;
    w_busy_n       = r_busy;
    w_master_sel_n = r_master_sel;
    w_slave_en_n   = r_slave_en;
    w_err_n        = 1'b0;
    w_tcnt_n       = r_tcnt;
    w_last_n       = r_last;
    w_cap_start    = 1'b0;

    case (r_state)
      IDLE: begin
        w_grant_n    = '0;
        w_busy_n     = 1'b0;
        w_slave_en_n = '0;
        if (|approval_request) begin
          w_master_sel_n = w_winner;
          w_grant_n      = NUM_MASTERS'(1) << w_winner;
          w_busy_n       = 1'b1;
          w_state_n      = SELECT;
        end
      end
      SELECT: begin
        // abort outranks decode, so the capture is not even advanced
        if (!w_req_own) begin
          w_grant_n = '0;
          w_state_n = RELEASE;
        end else begin
          w_cap_start = 1'b1;
          if (w_cap_done) begin
            if (32'(w_index) < NUM_SLAVES) begin
              w_slave_en_n = NUM_SLAVES'(1) << w_index;
              w_tcnt_n     = '0;
              w_state_n    = CONNECTED;
            end else begin
              w_err_n   = 1'b1;
              w_grant_n = '0;
              w_state_n = RELEASE;
            end
          end
        end
      end
      CONNECTED: begin
        w_tcnt_n = r_tcnt + TCW'(1);
        if (!w_req_own || w_done_own || (r_tcnt == TCW'(TIMEOUT - 1))) begin
          w_err_n      = w_req_own && !w_done_own;
          w_grant_n    = '0;
          w_slave_en_n = '0;
          w_state_n    = RELEASE;
        end
      end
      RELEASE: begin
        w_grant_n    = '0;
        w_slave_en_n = '0;
        w_busy_n     = 1'b0;
        w_last_n     = r_master_sel;
        w_state_n    = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_master_sel <= 1'b0;
      r_slave_en   <= '0;
      r_err        <= 1'b0;
      r_tcnt       <= '0;
      r_last       <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_grant      <= w_grant_n;
      r_busy       <= w_busy_n;
      r_master_sel <= w_master_sel_n;
      r_slave_en   <= w_slave_en_n;
      r_err        <= w_err_n;
      r_tcnt       <= w_tcnt_n;
      r_last       <= w_last_n;
    end
  end

  assign approval_grant = r_grant;
  assign busy           = r_busy;
  assign master_sel     = r_master_sel;
  assign slave_en       = r_slave_en;
  assign err            = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter (SLAVE_LEN=2, NUM_SLAVES=3, TIMEOUT=8).
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] approval_request;
  logic [1:0] tx_slave_select;
  logic [1:0] txn_done;
  logic [1:0] approval_grant;
  logic       busy;
  logic       master_sel;
  logic [2:0] slave_en;
  logic       err;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] req;
    logic [1:0] sel;
    logic [1:0] done;
    logic [1:0] g;
    logic       b;
    logic       ms;
    logic [2:0] sen;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  bus_arbiter #(
    .SLAVE_LEN (2),
    .NUM_SLAVES(3),
    .TIMEOUT   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .approval_request(approval_request),
    .tx_slave_select (tx_slave_select),
    .txn_done        (txn_done),
    .approval_grant  (approval_grant),
    .busy            (busy),
    .master_sel      (master_sel),
    .slave_en        (slave_en),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [1:0] req, input logic [1:0] sel, input logic [1:0] done,
                     input logic [1:0] g, input logic b, input logic ms,
                     input logic [2:0] sen, input logic e);
    vec_t v;
    v.req = req; v.sel = sel; v.done = done;
    v.g = g; v.b = b; v.ms = ms; v.sen = sen; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic [1:0] g, input logic b,
                           input logic ms, input logic [2:0] sen, input logic e);
    checks++;
    if (approval_grant !== g || busy !== b || master_sel !== ms || slave_en !== sen || err !== e) begin
      failures++;
      $display("FAIL %s: got grant=%b busy=%b msel=%b slave_en=%b err=%b, expected grant=%b busy=%b msel=%b slave_en=%b err=%b",
               name, approval_grant, busy, master_sel, slave_en, err, g, b, ms, sen, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants sampled on every falling edge while out of reset
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((approval_grant == 2'b11) || ((slave_en != 3'b000) && (approval_grant == 2'b00))) begin
        failures++;
        $display("FAIL invariant: grant=%b slave_en=%b", approval_grant, slave_en);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    approval_request = '0;
    tx_slave_select = '0;
    txn_done = '0;

    #12;
    check_out("reset_values", 2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Tie after reset: master 0 first (sends 0,1 -> slave 1), then master 1 after 2-cycle gap
    add(2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b11, 2'b01, 2'b00, 2'b01, 1, 0, 3'b010, 0);
    add(2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 3'b000, 0);
    add(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0);
    add(2'b11, 2'b00, 2'b00, 2'b10, 1, 1, 3'b000, 0);
    // Master 1 sends 1,1: invalid index -> err, RELEASE, IDLE
    add(2'b11, 2'b10, 2'b00, 2'b10, 1, 1, 3'b000, 0);
    add(2'b11, 2'b10, 2'b00, 2'b00, 1, 1, 3'b000, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 3'b000, 0);
    // Single request master 0, bits 1,0 -> slave 2, then done
    add(2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 3'b100, 0);
    add(2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 3'b000, 0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0);
    // Master 1 to slave 0, stray done from master 0, timeout after 8 connected cycles
    add(2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 3'b000, 0);
    add(2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 3'b000, 0);
    add(2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 3'b001, 0);
    for (int i = 0; i < 7; i++)
      add(2'b10, 2'b00, 2'b01, 2'b10, 1, 1, 3'b001, 0);
    add(2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 3'b000, 1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 3'b000, 0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 3'b000, 0);
    // Abort after first select bit: RELEASE without err, no slave enable
    add(2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 3'b000, 0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'b000, 0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0);

    foreach (vecs[i]) begin
      approval_request = vecs[i].req;
      tx_slave_select  = vecs[i].sel;
      txn_done         = vecs[i].done;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].ms, vecs[i].sen, vecs[i].e);
    end

    // Reset mid-CONNECTED: master 1 connects to slave 0, then async reset
    approval_request = 2'b10;
    tx_slave_select  = 2'b00;
    txn_done         = 2'b00;
    step();
    step();
    step();
    check_out("pre_reset_connected", 2'b10, 1'b1, 1'b1, 3'b001, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_out("async_reset_clear", 2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
    approval_request = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    step();
    check_out("tie_after_reset", 2'b01, 1'b1, 1'b0, 3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the serial system bus. Two master ports request bus ownership; the arbiter grants one with round-robin fairness, captures the granted master's bit-serial slave select, and enables the addressed slave. It holds the connection until the master signals completion or a watchdog expires. It drives the approval_grant and busy inputs of each master port and the enable lines of the slave ports.

## Interface
Parameters:
- SLAVE_LEN, 2, width of the serial slave-select field
- NUM_SLAVES, 3, number of attached slaves; valid indices are 0..NUM_SLAVES-1, with NUM_SLAVES ≤ 2**SLAVE_LEN
- TIMEOUT, 4095, maximum CONNECTED cycles before forced release; must be ≥1

Ports:
- clk  in  1  bus clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- approval_request  in  2  bit i is the bus request from master i
- tx_slave_select  in  2  bit i is master i's serial slave-select line
- txn_done  in  2  bit i is master i's end-of-transaction strobe
- approval_grant  out  2  one-hot grant, or 0
- busy  out  1  bus owned or releasing
- master_sel  out  1  index of the current or last granted master; drives the bus return mux
- slave_en  out  NUM_SLAVES  one-hot slave enable
- err  out  1  one-cycle pulse on timeout or invalid slave index

## Operation
- States: IDLE, SELECT, CONNECTED, RELEASE.
- **IDLE**
  - All outputs low except master_sel.
  - If any request is high, the arbiter picks a winner, sets master_sel to it and grants it, then goes to SELECT.
- **Round-robin pick**
  - A single requester wins.
  - If both request, the winner is the master not served last.
  - The last-served pointer resets to 1, so master 0 wins the first tie.
- **SELECT**
  - The arbiter shifts in SLAVE_LEN bits from tx_slave_select[master_sel], MSB first, one per cycle. A bit counter runs from 0 to SLAVE_LEN-1.
  - After the last bit:
    - index < NUM_SLAVES: set slave_en[index] and go to CONNECTED.
    - index ≥ NUM_SLAVES: pulse err and go to RELEASE.
- **CONNECTED**
  - The timeout counter starts at 0 on entry and increments each cycle.
  - txn_done[master_sel] high: go to RELEASE.
  - Counter reaches TIMEOUT-1 without done: pulse err and go to RELEASE.
- **Abort**
  - approval_request[master_sel] dropping in SELECT or CONNECTED causes a go to RELEASE, with no err.
  - In SELECT, abort takes priority over decode.
- **RELEASE**
  - grant=0, slave_en=0, busy=1, held for one cycle.
  - The last-served pointer is set to master_sel.
  - Next state is IDLE.
- Done or request lines of the non-granted master are ignored outside IDLE.
- txn_done during SELECT is ignored.

## Timing
- **Reset values:** approval_grant=0, busy=0, master_sel=0, slave_en=0, err=0, state=IDLE, counters=0, last-served pointer=1. Reset clears mid-transaction immediately, asynchronously.
- All outputs are registered.
- **Grant:** a request sampled at edge E0 gives grant and busy high after E0.
- **Select capture:** bits are sampled at edges E0+1 … E0+SLAVE_LEN. slave_en (or err) is asserted after E0+SLAVE_LEN.
- **Release:** done sampled at edge D gives grant and slave_en low after D, busy low after D+1.
- **Turnaround:** minimum grant-low gap between transactions is 2 cycles (RELEASE, IDLE).
- **Timeout:** with no done, the connection lasts exactly TIMEOUT cycles. err is high in the first RELEASE cycle.
- **Invariants:** grant is never two-hot, and slave_en is never asserted without grant.

## Structure
- Package bus_pkg:
  - state enum {IDLE, SELECT, CONNECTED, RELEASE}
  - NUM_MASTERS=2 constant
  - a shared localparam for the SLAVE_LEN default
- Sub-module serial_sel_capture:
  - shift register plus bit counter
  - inputs: clk, reset, start, bit_in
  - outputs: done and index[SLAVE_LEN-1:0]
- The arbiter FSM, round-robin pick and watchdog live in bus_arbiter.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- **Single request:** master 0 requests with serial bits 1,0 → grant=01 after one edge, slave_en=3'b100 two edges later; txn_done[0] → grant 0 next cycle, busy 0 one cycle after.
- **Simultaneous requests after reset:** master 0 is served first. On master 0's done, with both still requesting, master 1 is granted after the 2-cycle gap.
- **Invalid slave index:** master 1 sends 1,1 with NUM_SLAVES=3 → err pulses once, slave_en stays 0, RELEASE, then IDLE.
- **Timeout with TIMEOUT=8:** no done → slave_en high exactly 8 cycles, err pulse, bus freed.
- **Abort and stray done:**
  - Request dropped after the first select bit → RELEASE with no err and slave_en never set.
  - txn_done from the non-granted master in CONNECTED → ignored.
- **Reset mid-CONNECTED:** reset asserted → all outputs 0 immediately. After deassertion, master 0 wins the next tie.
